// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store initiator: RISC-V funct3 width codes,
// FSM state encoding, byte-lane mask constants and small decode helpers used
// by both the top level and the alignment/extension sub-module.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // RISC-V funct3 width/sign codes for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Byte-lane enable patterns (bit k = byte at addr+k)
    localparam logic [3:0] LANE_NONE = 4'b0000;
    localparam logic [3:0] LANE_B    = 4'b0001;
    localparam logic [3:0] LANE_H    = 4'b0011;
    localparam logic [3:0] LANE_W    = 4'b1111;

    // Lane mask from the width bits of funct3 (sign bit does not matter)
    function automatic logic [3:0] f3_lane_mask(input logic [2:0] f3);
        logic [3:0] mask;
        case (f3[1:0])
            2'b00:   mask = LANE_B;
            2'b01:   mask = LANE_H;
            2'b10:   mask = LANE_W;
            default: mask = LANE_NONE;
        endcase
        return mask;
    endfunction

    // Stores only have signed-style codes; unsigned codes are loads only
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Natural alignment check on the two low address bits
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational width handling for the load/store initiator.
// Request side: funct3 + low address bits -> lane mask, lane-masked store data
//               and an error flag (illegal funct3 or misaligned address).
// Load side:    funct3 + raw RAM read data -> sign/zero-extended result.
// Ports:
//   i_req_store, i_req_funct3, i_req_addr_lo, i_req_wdata : incoming request
//   o_req_mask, o_req_wdata, o_req_err                    : decoded request
//   i_ld_funct3, i_ld_rdata                               : latched width, RAM data
//   o_ld_data                                             : extended load result
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
#(
    parameter int w = 32,
    parameter int h = 8,
    parameter int l = 4
) (
    input  logic         i_req_store,
    input  logic [2:0]   i_req_funct3,
    input  logic [1:0]   i_req_addr_lo,
    input  logic [w-1:0] i_req_wdata,
    output logic [l-1:0] o_req_mask,
    output logic [w-1:0] o_req_wdata,
    output logic         o_req_err,
    input  logic [2:0]   i_ld_funct3,
    input  logic [w-1:0] i_ld_rdata,
    output logic [w-1:0] o_ld_data
);

    // Request decode: lane mask, per-lane data masking and legality
    always_comb begin
        o_req_mask  = f3_lane_mask(i_req_funct3);
        o_req_err   = ~f3_legal(i_req_store, i_req_funct3) |
                      f3_misaligned(i_req_funct3, i_req_addr_lo);
        o_req_wdata = {w{1'b0}};
        for (int k = 0; k < l; k++) begin
            o_req_wdata[k*h +: h] = o_req_mask[k] ? i_req_wdata[k*h +: h] : {h{1'b0}};
        end
    end

    // Load extension: the RAM returns zero in disabled lanes, so only the
    // sign bit of the narrow value needs replicating for LB/LH
    always_comb begin
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{(w-h){i_ld_rdata[h-1]}}, i_ld_rdata[h-1:0]};
            F3_BU:   o_ld_data = {{(w-h){1'b0}}, i_ld_rdata[h-1:0]};
            F3_H:    o_ld_data = {{(w-2*h){i_ld_rdata[2*h-1]}}, i_ld_rdata[2*h-1:0]};
            F3_HU:   o_ld_data = {{(w-2*h){1'b0}}, i_ld_rdata[2*h-1:0]};
            F3_W:    o_ld_data = i_ld_rdata;
            default: o_ld_data = {w{1'b0}};
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
// Load/store initiator between the core memory stage and a byte-lane data RAM.
// Accepts one request at a time (valid/ready), checks alignment/width, issues
// exactly one RAM access cycle and returns the result on a valid/ready
// response channel. Errors skip the RAM access entirely.
// Ports:
//   clk, rst_n                                   : clock, async active-low reset
//   req_valid/req_ready, req_store, req_funct3,
//   req_addr, req_wdata                          : request channel
//   ram_addr, ram_wdat, ram_we, ram_re, ram_type : RAM drive (registered, only
//                                                  non-zero during ACCESS)
//   ram_rdat                                     : RAM combinational read data
//   resp_valid/resp_ready, resp_data, resp_err   : response channel (registered)
// -----------------------------------------------------------------------------
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int w = 32,
    parameter int h = 8,
    parameter int l = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_store,
    input  logic [2:0]   req_funct3,
    input  logic [w-1:0] req_addr,
    input  logic [w-1:0] req_wdata,
    output logic [w-1:0] ram_addr,
    output logic [w-1:0] ram_wdat,
    output logic         ram_we,
    output logic         ram_re,
    output logic [l-1:0] ram_type,
    input  logic [w-1:0] ram_rdat,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [w-1:0] resp_data,
    output logic         resp_err
);

    lsu_state_t   r_state;
    lsu_state_t   w_next_state;

    logic [l-1:0] w_req_mask;
    logic [w-1:0] w_req_wdata;
    logic         w_req_err;
    logic [w-1:0] w_ld_data;
    logic         w_req_ready;

    logic         r_store;
    logic [2:0]   r_funct3;
    logic [w-1:0] r_ram_addr;
    logic [w-1:0] r_ram_wdat;
    logic         r_ram_we;
    logic         r_ram_re;
    logic [l-1:0] r_ram_type;
    logic         r_resp_valid;
    logic [w-1:0] r_resp_data;
    logic         r_resp_err;

    logic         w_store_nxt;
    logic [2:0]   w_funct3_nxt;
    logic [w-1:0] w_ram_addr_nxt;
    logic [w-1:0] w_ram_wdat_nxt;
    logic         w_ram_we_nxt;
    logic         w_ram_re_nxt;
    logic [l-1:0] w_ram_type_nxt;
    logic         w_resp_valid_nxt;
    logic [w-1:0] w_resp_data_nxt;
    logic         w_resp_err_nxt;

    lsu_align #(.w(w), .h(h), .l(l)) u_align (
        .i_req_store   (req_store),
        .i_req_funct3  (req_funct3),
        .i_req_addr_lo (req_addr[1:0]),
        .i_req_wdata   (req_wdata),
        .o_req_mask    (w_req_mask),
        .o_req_wdata   (w_req_wdata),
        .o_req_err     (w_req_err),
        .i_ld_funct3   (r_funct3),
        .i_ld_rdata    (ram_rdat),
        .o_ld_data     (w_ld_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; bad requests bypass ACCESS
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = w_req_err ? RESP : ACCESS;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACCESS: w_next_state = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RESP;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM output logic: ready from state alone, plus next values of the
    // registered RAM and response outputs. RAM controls default to zero so
    // they are high for the single ACCESS cycle only.
    always_comb begin
        w_req_ready      = (r_state == IDLE);
        w_store_nxt      = r_store;
        w_funct3_nxt     = r_funct3;
        w_ram_addr_nxt   = {w{1'b0}};
        w_ram_wdat_nxt   = {w{1'b0}};
        w_ram_we_nxt     = 1'b0;
        w_ram_re_nxt     = 1'b0;
        w_ram_type_nxt   = {l{1'b0}};
        w_resp_valid_nxt = r_resp_valid;
        w_resp_data_nxt  = r_resp_data;
        w_resp_err_nxt   = r_resp_err;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_store_nxt  = req_store;
                    w_funct3_nxt = req_funct3;
                    if (w_req_err) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_data_nxt  = {w{1'b0}};
                        w_resp_err_nxt   = 1'b1;
                    end else begin
                        w_ram_addr_nxt = req_addr;
                        w_ram_wdat_nxt = req_store ? w_req_wdata : {w{1'b0}};
                        w_ram_we_nxt   = req_store;
                        w_ram_re_nxt   = ~req_store;
                        w_ram_type_nxt = w_req_mask;
                    end
                end else begin
                    w_resp_valid_nxt = 1'b0;
                end
            end
            ACCESS: begin
                // Load data is sampled from the RAM at the end of this cycle
                w_resp_valid_nxt = 1'b1;
                w_resp_data_nxt  = r_store ? {w{1'b0}} : w_ld_data;
                w_resp_err_nxt   = 1'b0;
            end
            RESP: begin
                if (resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_resp_data_nxt  = {w{1'b0}};
                    w_resp_err_nxt   = 1'b0;
                end else begin
                    w_resp_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_resp_valid_nxt = 1'b0;
                w_resp_data_nxt  = {w{1'b0}};
                w_resp_err_nxt   = 1'b0;
            end
        endcase
    end

    // Request latch, RAM drive and response registers; async reset clears
    // the RAM strobes immediately, dropping any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store      <= 1'b0;
            r_funct3     <= 3'b000;
            r_ram_addr   <= {w{1'b0}};
            r_ram_wdat   <= {w{1'b0}};
            r_ram_we     <= 1'b0;
            r_ram_re     <= 1'b0;
            r_ram_type   <= {l{1'b0}};
            r_resp_valid <= 1'b0;
            r_resp_data  <= {w{1'b0}};
            r_resp_err   <= 1'b0;
        end else begin
            r_store      <= w_store_nxt;
            r_funct3     <= w_funct3_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_wdat   <= w_ram_wdat_nxt;
            r_ram_we     <= w_ram_we_nxt;
            r_ram_re     <= w_ram_re_nxt;
            r_ram_type   <= w_ram_type_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    assign req_ready  = w_req_ready;
    assign ram_addr   = r_ram_addr;
    assign ram_wdat   = r_ram_wdat;
    assign ram_we     = r_ram_we;
    assign ram_re     = r_ram_re;
    assign ram_type   = r_ram_type;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule
